product_fifo: RTL and testbench

PRODUCT_FIFO -- requirements
Module: product_fifo

---
 rtl/product_fifo.sv | 112 +++++++++++
 tb/tb_product_fifo.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/product_fifo.sv
// product_fifo: small registered FIFO that buffers finished multiplier
// products. It has no fall-through, so a product written in one cycle is
// visible on the next. A product that arrives while the FIFO is full is
// dropped and latches a sticky overflow flag. All status outputs are
// registered, so there is no combinational path from out_ready to in_ready.
module product_fifo #(
  parameter int WIDTH_FP  = 32,
  parameter int DEPTH     = 4,
  parameter int WIDTH_CNT = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 prod_valid,
  input  logic [WIDTH_FP-1:0]  product,
  output logic                 in_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH_FP-1:0]  out_product,
  output logic [WIDTH_CNT-1:0] count,
  output logic                 overflow
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Storage and pointers
  logic [WIDTH_FP-1:0]  mem_q [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [WIDTH_CNT-1:0] count_q, count_d;
  logic                 overflow_q, overflow_d;
  logic                 in_ready_q, in_ready_d;
  logic                 out_valid_q, out_valid_d;

  // Handshake qualifiers
  logic full_s;
  logic wr_en_s;
  logic rd_en_s;

  // Next-state logic: flags, handshakes, pointers, occupancy and overflow
  always_comb begin
    full_s      = (count_q == WIDTH_CNT'(DEPTH));
    wr_en_s     = prod_valid & ~full_s;
    rd_en_s     = out_valid_q & out_ready;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;

    if (wr_en_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (rd_en_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({wr_en_s, rd_en_s})
      2'b10:   count_d = count_q + WIDTH_CNT'(1);
      2'b01:   count_d = count_q - WIDTH_CNT'(1);
      default: count_d = count_q;
    endcase

    // A product offered while full is lost; remember it until reset.
    if (prod_valid && full_s) begin
      overflow_d = 1'b1;
    end else begin
      overflow_d = overflow_q;
    end

    in_ready_d  = (count_d != WIDTH_CNT'(DEPTH));
    out_valid_d = (count_d != WIDTH_CNT'(0));
  end

  // Control state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= PTR_W'(0);
      rd_ptr_q    <= PTR_W'(0);
      count_q     <= WIDTH_CNT'(0);
      overflow_q  <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Data array write; contents are not cleared, reset only blocks the write
  always_ff @(posedge clk) begin
    if (wr_en_s && !reset) begin
      mem_q[wr_ptr_q] <= product;
    end
  end

  assign out_product = mem_q[rd_ptr_q];
  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign count       = count_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_product_fifo.sv
// Self-checking bench for product_fifo: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_product_fifo;

  localparam int WIDTH_FP  = 32;
  localparam int DEPTH     = 4;
  localparam int WIDTH_CNT = 3;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 prod_valid;
  logic [WIDTH_FP-1:0]  product;
  logic                 in_ready;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH_FP-1:0]  out_product;
  logic [WIDTH_CNT-1:0] count;
  logic                 overflow;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [WIDTH_FP-1:0] model_q[$];
  logic                model_ovf = 1'b0;

  product_fifo #(.WIDTH_FP(WIDTH_FP), .DEPTH(DEPTH), .WIDTH_CNT(WIDTH_CNT)) dut (
    .clk         (clk),
    .reset       (reset),
    .prod_valid  (prod_valid),
    .product     (product),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_product (out_product),
    .count       (count),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Compare every observable output against the model
  task automatic check_all(input string tag);
    check({tag, ".count"},     32'(count),     32'(model_q.size()));
    check({tag, ".in_ready"},  32'(in_ready),  32'(model_q.size() < DEPTH));
    check({tag, ".out_valid"}, 32'(out_valid), 32'(model_q.size() > 0));
    check({tag, ".overflow"},  32'(overflow),  32'(model_ovf));
    if (model_q.size() > 0) begin
      check({tag, ".out_product"}, out_product, model_q[0]);
    end
  endtask

  // One clock cycle: drive inputs, advance the model, sample after the edge
  task automatic step(input string tag, input logic rst, input logic pv,
                      input logic [WIDTH_FP-1:0] d, input logic ordy);
    bit was_full;
    bit do_rd;
    @(negedge clk);
    reset      = rst;
    prod_valid = pv;
    product    = d;
    out_ready  = ordy;
    if (rst) begin
      model_q.delete();
      model_ovf = 1'b0;
    end else begin
      was_full = (model_q.size() == DEPTH);
      do_rd    = (model_q.size() > 0) && ordy;
      if (pv && was_full) model_ovf = 1'b1;
      if (do_rd) void'(model_q.pop_front());
      if (pv && !was_full) model_q.push_back(d);
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    logic [WIDTH_FP-1:0] held;
    reset = 1'b1; prod_valid = 1'b0; product = '0; out_ready = 1'b0;

    // Power-up reset
    step("reset0", 1'b1, 1'b0, 32'h0, 1'b0);
    step("reset1", 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1);

    // Single pass
    step("single_wr",   1'b0, 1'b1, 32'h0000_0006, 1'b0);
    check("single_val", out_product, 32'h0000_0006);
    step("single_rd",   1'b0, 1'b0, 32'h0, 1'b1);
    check("single_empty", 32'(count), 32'd0);

    // Fill, overflow, drain
    step("fill1", 1'b0, 1'b1, 32'h11, 1'b0);
    step("fill2", 1'b0, 1'b1, 32'h22, 1'b0);
    step("fill3", 1'b0, 1'b1, 32'h33, 1'b0);
    step("fill4", 1'b0, 1'b1, 32'h44, 1'b0);
    check("fill_inready", 32'(in_ready), 32'd0);
    step("fill5_drop", 1'b0, 1'b1, 32'h55, 1'b0);
    check("fill_ovf", 32'(overflow), 32'd1);
    for (int i = 0; i < 4; i++) begin
      check("drain_order", out_product, 32'(8'h11 * (i + 1)));
      step("drain", 1'b0, 1'b0, 32'h0, 1'b1);
    end

    // Wrap-around with interleaved reads
    step("wrap_rst", 1'b1, 1'b0, 32'h0, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      step("wrap_wr", 1'b0, 1'b1, 32'(i), (i % 3) == 0);
      if ((i % 2) == 0) step("wrap_rd", 1'b0, 1'b0, 32'h0, 1'b1);
    end
    while (model_q.size() > 0) step("wrap_drain", 1'b0, 1'b0, 32'h0, 1'b1);
    check("wrap_ovf", 32'(overflow), 32'd0);

    // Simultaneous write and read at count=2, then at full
    step("sim_wr1", 1'b0, 1'b1, 32'h1, 1'b0);
    step("sim_wr2", 1'b0, 1'b1, 32'h2, 1'b0);
    step("sim_aa",  1'b0, 1'b1, 32'hAA, 1'b1);
    check("sim_cnt2", 32'(count), 32'd2);
    step("sim_wr3", 1'b0, 1'b1, 32'h3, 1'b0);
    step("sim_wr4", 1'b0, 1'b1, 32'h4, 1'b0);
    step("sim_bb",  1'b0, 1'b1, 32'hBB, 1'b1);
    check("sim_cnt3", 32'(count), 32'd3);
    check("sim_ovf",  32'(overflow), 32'd1);
    while (model_q.size() > 0) step("sim_drain", 1'b0, 1'b0, 32'h0, 1'b1);

    // Reset mid-operation with a concurrent write
    step("mid_rst0", 1'b1, 1'b0, 32'h0, 1'b0);
    step("mid_w1", 1'b0, 1'b1, 32'h1, 1'b0);
    step("mid_w2", 1'b0, 1'b1, 32'h2, 1'b0);
    step("mid_w3", 1'b0, 1'b1, 32'h3, 1'b0);
    step("mid_rst", 1'b1, 1'b1, 32'h9, 1'b0);
    check("mid_cnt0", 32'(count), 32'd0);
    step("mid_w7", 1'b0, 1'b1, 32'h7, 1'b0);
    check("mid_first", out_product, 32'h7);

    // Backpressure stability
    held = out_product;
    for (int i = 0; i < 5; i++) begin
      step("hold", 1'b0, 1'b0, $urandom, 1'b0);
      check("hold_data",  out_product, held);
      check("hold_valid", 32'(out_valid), 32'd1);
    end

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step("rand", ($urandom_range(0, 39) == 0), 1'(($urandom_range(0, 2)) != 0),
           $urandom, 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
